// File: rtl/mrd_source_stream.sv
// Purpose : egress stage of the mixed-radix DFT core; reads the result RAM in natural order, streams it out
// Latency : first src_valid RD_LAT+1 cycles after the accepted start; one beat per cycle with src_ready held high
// Backpr. : reads are credit-gated so the FIFO never overflows; output beats hold stable while src_ready is low
//
// Ports:
//   clk, rst_n                      core clock, asynchronous active-low reset
//   start, dftpts_in, inverse_in    frame request from the controller (N and IDFT flag latched on accept)
//   busy, done                      frame in progress / one-cycle completion pulse after the eop beat
//   rd_en, rd_bank_index/addr       read port into the 5-bank result RAM
//   rd_real, rd_imag                read data, valid RD_LAT cycles after rd_en
//   src_*                           valid/ready/sop/eop sample stream plus frame attributes

// Small synchronous FIFO with combinational read port and occupancy count.
// Latency: one cycle from push to visibility at dout.
// Backpressure: push while full and pop while empty are dropped; callers guarantee neither occurs.
module mrd_fifo #(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly because D need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (count != CW'(D));
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < D; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module mrd_source_stream #(
    parameter int DW     = 18,
    parameter int PTS_W  = 12,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2,
    parameter int FIFO_D = RD_LAT + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PTS_W-1:0]  dftpts_in,
    input  logic              inverse_in,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [2:0]        rd_bank_index,
    output logic [ADDR_W-1:0] rd_bank_addr,
    input  logic [DW-1:0]     rd_real,
    input  logic [DW-1:0]     rd_imag,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop,
    output logic [DW-1:0]     src_real,
    output logic [DW-1:0]     src_imag,
    output logic [PTS_W-1:0]  src_dftpts,
    output logic              src_inverse
);
    localparam int OCC_W = $clog2(FIFO_D + 1);
    localparam int CRD_W = OCC_W + 1;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PTS_W-1:0]   n_q;
    logic               inv_q;
    logic               busy_q;
    logic               done_q;
    logic [PTS_W-1:0]   k_q;
    logic [2:0]         bank_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [RD_LAT-1:0]  vld_sr;
    logic [RD_LAT-1:0]  sop_sr;
    logic [RD_LAT-1:0]  eop_sr;
    logic [OCC_W-1:0]   inflight_q;

    logic               start_ok;
    logic [PTS_W-1:0]   n_eff;
    logic               credit_ok;
    logic               issue;
    logic               last_rd;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic [OCC_W-1:0]   fifo_cnt;
    beat_t              fifo_din;
    beat_t              fifo_dout;
    logic               eop_acc;

    assign start_ok = (state_q == IDLE) & start & (dftpts_in != '0);

    // The first read goes out in the start cycle itself, before N is latched,
    // so the frame length is taken straight from the input for that cycle.
    assign n_eff = start_ok ? dftpts_in : n_q;

    // Every issued read already owns a FIFO slot: words still in the RAM
    // pipeline plus words parked in the FIFO never exceed the FIFO depth.
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt}) < CRD_W'(FIFO_D);

    assign issue   = start_ok | ((state_q == ISSUE) & credit_ok);
    assign last_rd = issue & (k_q == (n_eff - PTS_W'(1)));

    assign fifo_push    = vld_sr[RD_LAT-1];
    assign fifo_din.sop = sop_sr[RD_LAT-1];
    assign fifo_din.eop = eop_sr[RD_LAT-1];
    assign fifo_din.re  = rd_real;
    assign fifo_din.im  = rd_imag;

    assign src_valid = ~fifo_empty;
    assign fifo_pop  = src_valid & src_ready;
    assign eop_acc   = (state_q == DRAIN) & fifo_pop & fifo_dout.eop;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = last_rd ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (last_rd) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (eop_acc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame attributes and busy/done handshake with the controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q    <= '0;
            inv_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= eop_acc;
            if (start_ok) begin
                n_q    <= dftpts_in;
                inv_q  <= inverse_in;
                busy_q <= 1'b1;
            end else if (eop_acc) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Natural-order address walk: k -> (k mod 5, k div 5) without a divider.
    // Counters return to zero once the last read is out, ready for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= '0;
            bank_q <= '0;
            addr_q <= '0;
        end else if (issue) begin
            if (last_rd) begin
                k_q    <= '0;
                bank_q <= '0;
                addr_q <= '0;
            end else begin
                k_q <= k_q + PTS_W'(1);
                if (bank_q == 3'd4) begin
                    bank_q <= '0;
                    addr_q <= addr_q + ADDR_W'(1);
                end else begin
                    bank_q <= bank_q + 3'd1;
                end
            end
        end
    end

    // Tag pipeline mirrors the RAM read latency; sop/eop ride with each word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr     <= '0;
            sop_sr     <= '0;
            eop_sr     <= '0;
            inflight_q <= '0;
        end else begin
            vld_sr[0] <= issue;
            sop_sr[0] <= issue & (k_q == '0);
            eop_sr[0] <= last_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                sop_sr[i] <= sop_sr[i-1];
                eop_sr[i] <= eop_sr[i-1];
            end
            case ({issue, fifo_push})
                2'b10:   inflight_q <= inflight_q + OCC_W'(1);
                2'b01:   inflight_q <= inflight_q - OCC_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    mrd_fifo #(
        .W  ($bits(beat_t)),
        .D  (FIFO_D),
        .CW (OCC_W)
    ) u_out_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign rd_en         = issue;
    assign rd_bank_index = bank_q;
    assign rd_bank_addr  = addr_q;
    assign src_sop       = fifo_dout.sop;
    assign src_eop       = fifo_dout.eop;
    assign src_real      = fifo_dout.re;
    assign src_imag      = fifo_dout.im;
    assign src_dftpts    = n_q;
    assign src_inverse   = inv_q;
endmodule

// File: tb/tb_mrd_source_stream.sv
`timescale 1ns/1ps
// Bench for mrd_source_stream: RAM model with fixed read latency, directed frames,
// scoreboard queues for the read sequence and the output beats.
module tb_mrd_source_stream;
    localparam int DW     = 18;
    localparam int PTS_W  = 12;
    localparam int ADDR_W = 10;
    localparam int RD_LAT = 2;
    localparam int FIFO_D = RD_LAT + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [PTS_W-1:0]  dftpts_in = '0;
    logic              inverse_in = 1'b0;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [2:0]        rd_bank_index;
    logic [ADDR_W-1:0] rd_bank_addr;
    logic [DW-1:0]     rd_real;
    logic [DW-1:0]     rd_imag;
    logic              src_valid;
    logic              src_ready = 1'b0;
    logic              src_sop;
    logic              src_eop;
    logic [DW-1:0]     src_real;
    logic [DW-1:0]     src_imag;
    logic [PTS_W-1:0]  src_dftpts;
    logic              src_inverse;

    always #5 clk = ~clk;

    mrd_source_stream #(
        .DW(DW), .PTS_W(PTS_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dftpts_in(dftpts_in), .inverse_in(inverse_in),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_bank_index(rd_bank_index),
        .rd_bank_addr(rd_bank_addr), .rd_real(rd_real), .rd_imag(rd_imag),
        .src_valid(src_valid), .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop),
        .src_real(src_real), .src_imag(src_imag), .src_dftpts(src_dftpts), .src_inverse(src_inverse)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // RAM content is a function of (salt, bank, addr); salt changes per frame.
    logic [4:0] salt = 5'd0;

    function automatic logic [DW-1:0] mk_re(input logic [4:0] s, input logic [2:0] b,
                                            input logic [ADDR_W-1:0] a);
        return {s, b, a};
    endfunction

    logic [DW-1:0] pre [RD_LAT];
    logic [DW-1:0] pim [RD_LAT];

    always @(posedge clk) begin
        if (rd_en) begin
            pre[0] <= mk_re(salt, rd_bank_index, rd_bank_addr);
            pim[0] <= mk_re(salt, rd_bank_index, rd_bank_addr) ^ 18'h25A5A;
        end else begin
            pre[0] <= 18'h3FFFF;
            pim[0] <= 18'h15555;
        end
        for (int i = 1; i < RD_LAT; i++) begin
            pre[i] <= pre[i-1];
            pim[i] <= pim[i-1];
        end
    end
    assign rd_real = pre[RD_LAT-1];
    assign rd_imag = pim[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboards
    logic [ADDR_W+2:0] exp_rd [$];
    logic [2*DW+1:0]   exp_beat [$];
    logic [PTS_W-1:0]  exp_dftpts = '0;
    logic              exp_inv = 1'b0;

    // Monitor-owned observation state
    int                rd_cnt = 0;
    int                beat_cnt = 0;
    int                done_cnt = 0;
    int                vld_rise_cyc = 0;
    int                eop_cyc = 0;
    int                outstanding = 0;
    int                max_out = 0;
    logic [ADDR_W+2:0] last_rd = '0;
    logic              stall_prev = 1'b0;
    logic              vld_prev = 1'b0;
    logic [2*DW+1:0]   held = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev  = 1'b0;
            vld_prev    = 1'b0;
            outstanding = 0;
        end else begin
            if (rd_en) begin
                rd_cnt++;
                outstanding++;
                last_rd = {rd_bank_index, rd_bank_addr};
                if (exp_rd.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_extra: unexpected read bank %0d addr %0d", rd_bank_index, rd_bank_addr);
                end else begin
                    chk("rd_seq", {rd_bank_index, rd_bank_addr}, exp_rd.pop_front());
                end
            end
            if (stall_prev) begin
                chk("stall_hold", {src_valid, src_sop, src_eop, src_real, src_imag}, {1'b1, held});
            end
            if (src_valid && !vld_prev) vld_rise_cyc = cyc;
            if (src_valid && src_ready) begin
                beat_cnt++;
                outstanding--;
                if (exp_beat.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_extra: unexpected beat re 0x%0h", src_real);
                end else begin
                    chk("beat", {src_sop, src_eop, src_real, src_imag}, exp_beat.pop_front());
                end
                chk("frame_attr", {src_dftpts, src_inverse}, {exp_dftpts, exp_inv});
                if (src_eop) eop_cyc = cyc;
            end
            if (outstanding > max_out) max_out = outstanding;
            if (done) begin
                done_cnt++;
                chk("done_timing", cyc, eop_cyc + 1);
                chk("busy_at_done", busy, 1'b0);
            end
            stall_prev = src_valid && !src_ready;
            held       = {src_sop, src_eop, src_real, src_imag};
            vld_prev   = src_valid;
        end
    end

    function automatic logic rdy(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return ((c % 4) == 0) || ((c % 4) == 3);
            default: return 1'($urandom_range(1, 0));
        endcase
    endfunction

    task automatic push_exp(input int n, input logic inv);
        logic [2:0]        b;
        logic [ADDR_W-1:0] a;
        salt       = salt + 5'd1;
        exp_dftpts = PTS_W'(n);
        exp_inv    = inv;
        for (int k = 0; k < n; k++) begin
            b = 3'(k % 5);
            a = ADDR_W'(k / 5);
            exp_rd.push_back({b, a});
            exp_beat.push_back({k == 0, k == n - 1, mk_re(salt, b, a), mk_re(salt, b, a) ^ 18'h25A5A});
        end
    endtask

    int start_cyc = 0;

    // Drives a one-cycle start, then scrambles dftpts_in/inverse_in to prove they are latched.
    task automatic pulse_start(input int n, input logic inv, input logic rdy0);
        @(posedge clk); #1;
        start      = 1'b1;
        dftpts_in  = PTS_W'(n);
        inverse_in = inv;
        src_ready  = rdy0;
        start_cyc  = cyc;
        @(posedge clk); #1;
        start      = 1'b0;
        dftpts_in  = 12'hABC;
        inverse_in = ~inv;
    endtask

    task automatic run_frame(input int n, input logic inv, input int mode, input logic midstart);
        int b0;
        int d0;
        push_exp(n, inv);
        b0 = beat_cnt;
        d0 = done_cnt;
        pulse_start(n, inv, rdy(mode, 0));
        chk("busy_after_start", busy, 1'b1);
        for (int c = 1; c < 8000 && done_cnt == d0; c++) begin
            src_ready = rdy(mode, c);
            if (midstart && (c % 97) == 50 && c < 1000) begin
                start     = 1'b1;
                dftpts_in = 12'd7;
            end else begin
                start     = 1'b0;
            end
            @(posedge clk); #1;
        end
        start     = 1'b0;
        src_ready = 1'b1;
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL frame_timeout: N=%0d beats=%0d", n, beat_cnt - b0);
        end
        chk("beat_count", beat_cnt - b0, n);
        chk("done_count", done_cnt - d0, 1);
        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("beat_queue_empty", exp_beat.size(), 0);
        chk("outstanding_le_depth", max_out <= FIFO_D, 1'b1);
    endtask

    initial begin
        int b0;
        int d0;
        int r0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {busy, done, rd_en, rd_bank_index, rd_bank_addr, src_valid, src_sop, src_eop,
                         src_inverse, src_dftpts}, 64'd0);
        chk("rst_data", {src_real, src_imag}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_ctrl", {busy, done, rd_en, src_valid, src_sop, src_eop}, 64'd0);

        // start with N = 0 must be ignored
        r0 = rd_cnt;
        d0 = done_cnt;
        pulse_start(0, 1'b0, 1'b1);
        chk("zero_start_busy", busy, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("zero_start_no_rd", rd_cnt - r0, 0);
        chk("zero_start_no_done", done_cnt - d0, 0);
        chk("zero_start_attr", {src_dftpts, src_inverse}, 64'd0);

        // Basic frame, ready held high
        run_frame(12, 1'b0, 0, 1'b0);
        chk("first_valid_latency", vld_rise_cyc - start_cyc, RD_LAT + 1);
        chk("back_to_back_beats", eop_cyc - vld_rise_cyc, 11);
        chk("basic_last_rd", last_rd, {3'd1, 10'd2});

        // Backpressure 1,0,0,1
        run_frame(60, 1'b0, 1, 1'b0);
        chk("bp_last_rd", last_rd, {3'd4, 10'd11});

        // Single point IDFT frame
        run_frame(1, 1'b1, 0, 1'b0);
        chk("single_attr_held", {src_dftpts, src_inverse}, {12'd1, 1'b1});

        // Max frame, random ready, stray start pulses mid-frame
        run_frame(1200, 1'b0, 2, 1'b1);
        chk("max_last_rd", last_rd, {3'd4, 10'd239});

        // Reset mid-frame
        push_exp(36, 1'b0);
        b0 = beat_cnt;
        d0 = done_cnt;
        pulse_start(36, 1'b0, 1'b1);
        for (int c = 0; c < 500 && (beat_cnt - b0) < 6; c++) begin
            @(posedge clk); #1;
        end
        chk("abort_point", beat_cnt - b0, 6);
        rst_n = 1'b0;
        exp_rd.delete();
        exp_beat.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("abort_rst_ctrl", {busy, done, rd_en, rd_bank_index, rd_bank_addr, src_valid, src_sop, src_eop,
                               src_inverse, src_dftpts}, 64'd0);
        chk("abort_rst_data", {src_real, src_imag}, 64'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle", {busy, src_valid}, 64'd0);
        run_frame(36, 1'b0, 0, 1'b0);
        chk("refill_last_rd", last_rd, {3'd0, 10'd7});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
